// File: rtl/primes_seq.sv
// Iterative primality tester: trial division by 2, 3, 5, 7, ... with a restoring
// shift-subtract divider, stopping at the first divisor or once d*d exceeds the operand.
module primes_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic [WIDTH-1:0] factor
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_EVAL,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]   dvsr_next;
  logic               sq_over;
  logic [2*WIDTH-1:0] step;
  logic               trivial;
  logic               last_bit;

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. Returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] dv);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] qn;
    sh = {r, q[WIDTH-1]};
    if (sh >= {1'b0, dv}) begin
      sh = sh - {1'b0, dv};
      qn = {q[WIDTH-2:0], 1'b1};
    end else begin
      qn = {q[WIDTH-2:0], 1'b0};
    end
    return {sh[WIDTH-1:0], qn};
  endfunction

  function automatic logic [WIDTH-1:0] next_divisor(input logic [WIDTH-1:0] dv);
    return (dv == WIDTH'(2)) ? WIDTH'(3) : dv + WIDTH'(2);
  endfunction

  // Square taken at double width so it cannot wrap for any operand.
  function automatic logic square_exceeds(input logic [WIDTH-1:0] dv,
                                          input logic [WIDTH-1:0] op);
    logic [2*WIDTH-1:0] sq;
    sq = {{WIDTH{1'b0}}, dv} * {{WIDTH{1'b0}}, dv};
    return sq > {{WIDTH{1'b0}}, op};
  endfunction

  assign dvsr_next = next_divisor(dvsr);
  assign sq_over   = square_exceeds(dvsr_next, opnd);
  assign step      = div_step(rem, quo, dvsr);
  assign trivial   = opnd < WIDTH'(4);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_CHECK;
      end
      S_CHECK: begin
        busy    = 1'b1;
        state_n = trivial ? S_DONE : S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_bit) state_n = S_EVAL;
      end
      S_EVAL: begin
        busy    = 1'b1;
        state_n = ((rem == '0) || sq_over) ? S_DONE : S_DIV;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd   <= '0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      z      <= 1'b0;
      factor <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) opnd <= x;
        end
        S_CHECK: begin
          if (trivial) begin
            z      <= (opnd >= WIDTH'(2));
            factor <= '0;
          end else begin
            dvsr <= WIDTH'(2);
            rem  <= '0;
            quo  <= opnd;
            cnt  <= '0;
          end
        end
        S_DIV: begin
          rem <= step[2*WIDTH-1:WIDTH];
          quo <= step[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
        end
        S_EVAL: begin
          if (rem == '0) begin
            z      <= 1'b0;
            factor <= dvsr;
          end else if (sq_over) begin
            z      <= 1'b1;
            factor <= '0;
          end else begin
            // Reload the dividend and retry with the next candidate divisor.
            dvsr <= dvsr_next;
            rem  <= '0;
            quo  <= opnd;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_primes_seq.sv
// Scoreboard bench for primes_seq (WIDTH=8): expected results are queued when a
// test is started and compared when the done pulse appears.
module tb_primes_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic       busy, done, z;
  logic [7:0] factor;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       z;
    logic [7:0] f;
    int         lat;
  } exp_t;

  exp_t sb[$];

  primes_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .busy(busy), .done(done), .z(z), .factor(factor)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [7:0] xv);
    @(negedge clk);
    x = xv;
    start = 1'b1;
  endtask

  // Waits for done; cycle 1 is the first cycle after the accepting edge.
  task automatic wait_done(input bit hold, output logic oz, output logic [7:0] of,
                           output int lat, output bit busy_err, output bit both_err);
    lat = -1; oz = 1'b0; of = '0; busy_err = 1'b0; both_err = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      else if (c == 3) x = 8'd12;
      if (done && busy) both_err = 1'b1;
      if (done) begin
        lat = c; oz = z; of = factor; start = 1'b0;
        break;
      end
      if (!busy) busy_err = 1'b1;
    end
  endtask

  function automatic exp_t model(input int xv);
    exp_t e;
    int d, k, dn;
    e.z = 1'b0; e.f = '0; e.lat = 2;
    if (xv < 2) return e;
    e.z = 1'b1;
    for (int f = 2; f * f <= xv; f++) begin
      if (xv % f == 0) begin e.z = 1'b0; e.f = 8'(f); break; end
    end
    if (xv < 4) return e;
    d = 2; k = 0;
    forever begin
      k++;
      if (xv % d == 0) break;
      dn = (d == 2) ? 3 : d + 2;
      if (dn * dn > xv) break;
      d = dn;
    end
    e.lat = 2 + k * 9;
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    if (z !== 1'b0)     begin n_fail++; $display("FAIL reset_z got=%b want=0", z); end
    if (factor !== 8'd0) begin n_fail++; $display("FAIL reset_factor got=%0d want=0", factor); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known;
    logic [7:0] xs[4]   = '{8'd1, 8'd2, 8'd4, 8'd9};
    logic       zs[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] fs[4]   = '{8'd0, 8'd0, 8'd2, 8'd3};
    int         lats[4] = '{2, 2, 11, 20};
    logic oz; logic [7:0] of; int lat; bit be, bb; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{zs[i], fs[i], lats[i]});
      do_start(xs[i]);
      wait_done(1'b0, oz, of, lat, be, bb);
      e = sb.pop_front();
      n_checks += 5;
      if (oz !== e.z)  begin n_fail++; $display("FAIL known_z x=%0d got=%b want=%b", xs[i], oz, e.z); end
      if (of !== e.f)  begin n_fail++; $display("FAIL known_factor x=%0d got=%0d want=%0d", xs[i], of, e.f); end
      if (lat != e.lat) begin n_fail++; $display("FAIL known_latency x=%0d got=%0d want=%0d", xs[i], lat, e.lat); end
      if (be)          begin n_fail++; $display("FAIL known_busy x=%0d got=gap want=high_until_done", xs[i]); end
      if (bb)          begin n_fail++; $display("FAIL known_done_busy x=%0d got=both want=exclusive", xs[i]); end
    end
  endtask

  task automatic test_prime_251;
    logic oz; logic [7:0] of; int lat; bit be, bb; exp_t e;
    sb.push_back('{1'b1, 8'd0, 74});
    do_start(8'd251);
    wait_done(1'b0, oz, of, lat, be, bb);
    e = sb.pop_front();
    n_checks += 5;
    if (oz !== e.z)   begin n_fail++; $display("FAIL p251_z got=%b want=%b", oz, e.z); end
    if (of !== e.f)   begin n_fail++; $display("FAIL p251_factor got=%0d want=%0d", of, e.f); end
    if (lat != e.lat) begin n_fail++; $display("FAIL p251_latency got=%0d want=%0d", lat, e.lat); end
    if (be)           begin n_fail++; $display("FAIL p251_busy got=gap want=high_cycles_1_to_73"); end
    if (bb)           begin n_fail++; $display("FAIL p251_done_busy got=both want=exclusive"); end
    @(negedge clk);
    n_checks += 2;
    if (done !== 1'b0) begin n_fail++; $display("FAIL p251_done_width got=%b want=0", done); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL p251_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_start_held;
    logic oz; logic [7:0] of; int lat; bit be, bb; exp_t e; int extra;
    sb.push_back('{1'b1, 8'd0, 20});
    do_start(8'd13);
    wait_done(1'b1, oz, of, lat, be, bb);
    e = sb.pop_front();
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks += 4;
    if (oz !== e.z)   begin n_fail++; $display("FAIL held_z got=%b want=%b", oz, e.z); end
    if (of !== e.f)   begin n_fail++; $display("FAIL held_factor got=%0d want=%0d", of, e.f); end
    if (lat != e.lat) begin n_fail++; $display("FAIL held_latency got=%0d want=%0d", lat, e.lat); end
    if (extra != 0)   begin n_fail++; $display("FAIL held_second_test got=%0d active_cycles want=0", extra); end
    n_checks += 1;
    if (z !== 1'b1)   begin n_fail++; $display("FAIL held_z_hold got=%b want=1", z); end
  endtask

  task automatic test_reset_abort;
    logic oz; logic [7:0] of; int lat; bit be, bb; exp_t e; int seen;
    do_start(8'd255);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL abort_done got=%b want=0", done); end
    if (z !== 1'b0)      begin n_fail++; $display("FAIL abort_z got=%b want=0", z); end
    if (factor !== 8'd0) begin n_fail++; $display("FAIL abort_factor got=%0d want=0", factor); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks += 1;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d active_cycles want=0", seen); end
    sb.push_back('{1'b0, 8'd3, 20});
    do_start(8'd255);
    wait_done(1'b0, oz, of, lat, be, bb);
    e = sb.pop_front();
    n_checks += 3;
    if (oz !== e.z)   begin n_fail++; $display("FAIL restart_z got=%b want=%b", oz, e.z); end
    if (of !== e.f)   begin n_fail++; $display("FAIL restart_factor got=%0d want=%0d", of, e.f); end
    if (lat != e.lat) begin n_fail++; $display("FAIL restart_latency got=%0d want=%0d", lat, e.lat); end
  endtask

  task automatic test_sweep;
    logic oz; logic [7:0] of; int lat; bit be, bb; exp_t e;
    for (int v = 0; v < 256; v++) begin
      sb.push_back(model(v));
      do_start(8'(v));
      wait_done(1'b0, oz, of, lat, be, bb);
      e = sb.pop_front();
      n_checks += 4;
      if (oz !== e.z)   begin n_fail++; $display("FAIL sweep_z x=%0d got=%b want=%b", v, oz, e.z); end
      if (of !== e.f)   begin n_fail++; $display("FAIL sweep_factor x=%0d got=%0d want=%0d", v, of, e.f); end
      if (lat != e.lat) begin n_fail++; $display("FAIL sweep_latency x=%0d got=%0d want=%0d", v, lat, e.lat); end
      if (be || bb)     begin n_fail++; $display("FAIL sweep_busy x=%0d got=busy_err:%b both:%b want=0", v, be, bb); end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_prime_251();
    test_start_held();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/primes_seq.md
PRIMES_SEQ -- requirements
Module: primes_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the input operand width in bits; legal range 3..16.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to test x; sampled only in IDLE.
REQ-005 SHALL have port x, input, WIDTH bits, unsigned operand; sampled only on the accepting edge.
REQ-006 SHALL have port busy, output, 1 bit, high while a test is in progress.
REQ-007 SHALL have port done, output, 1 bit, one-cycle pulse when a result is available.
REQ-008 SHALL have port z, output, 1 bit, result: 0 = not prime, 1 = prime.
REQ-009 SHALL have port factor, output, WIDTH bits, smallest divisor >= 2 when composite; 0 otherwise.

Function
REQ-010 SHALL implement the states IDLE, CHECK, DIV, EVAL and DONE as a registered FSM.
REQ-011 In IDLE, a rising edge with start=1 SHALL latch x into an internal operand register and move to CHECK; x changes afterwards SHALL have no effect.
REQ-012 start SHALL be ignored in CHECK, DIV, EVAL and DONE, with no queuing.
REQ-013 CHECK SHALL last 1 cycle with these exits:
- operand < 2: z=0, factor=0, go to DONE.
- operand = 2 or 3: z=1, factor=0, go to DONE.
- otherwise: divisor d=2, go to DIV.
REQ-014 DIV SHALL last exactly WIDTH cycles and SHALL compute operand mod d by restoring shift-subtract division, one quotient bit per cycle, MSB first; then go to EVAL.
REQ-015 EVAL SHALL last 1 cycle with these exits:
- remainder = 0: z=0, factor=d, go to DONE.
- otherwise: d_next = 3 if d=2, else d+2.
- if d_next*d_next > operand (2*WIDTH-bit unsigned compare): z=1, factor=0, go to DONE.
- else: d=d_next, go to DIV.
REQ-016 d SHALL be WIDTH bits wide; the square SHALL be computed at 2*WIDTH bits so no wrap-around occurs for any operand.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 exactly in CHECK, DIV and EVAL; it SHALL be 0 in IDLE and DONE.
REQ-019 z and factor SHALL be registered, written only on entry to DONE, and held unchanged until the next DONE entry.
REQ-020 Latency, counted from the accepting edge (cycle 0), SHALL be 1 + k*(WIDTH+1) + 1 cycles to the done pulse, where k = number of divisors tested (k=0 for trivial cases).
REQ-021 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-022 While rst=1, regardless of clk, the block SHALL force: state IDLE, busy=0, done=0, z=0, factor=0, internal operand, divisor and remainder registers to 0.
REQ-023 rst asserted mid-test SHALL abort the test with no done pulse.
REQ-024 After rst deasserts, the first start edge SHALL begin a fresh test.

Verification (WIDTH=8, cycles counted from the start edge)
REQ-025 x=1, then x=2 -> done at cycle 2: z=0, factor=0 for x=1; z=1, factor=0 for x=2.
REQ-026 x=4 -> done at cycle 11, z=0, factor=2. x=9 -> done at cycle 20, z=0, factor=3.
REQ-027 x=251 -> divisors 2,3,5,...,15 tested; done at cycle 74; z=1, factor=0; busy high during cycles 1..73.
REQ-028 x=13 with start held high and x changed to 12 during the test -> single done at cycle 20, z=1, factor=0; no second test started.
REQ-029 x=255, rst pulsed at cycle 5 -> no done pulse, all outputs 0; a new start with x=255 -> done 20 cycles later, z=0, factor=3.
REQ-030 Exhaustive sweep x=0..255 -> z matches a reference prime table; factor matches the smallest prime factor for every composite.
